// File: rtl/memory_game_pkg.sv
// Shared types and constants for the memory-tester game blocks.
// Holds the round state encoding, LFSR constants and the timeout-per-level helper.
package memory_game_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GEN   = 3'd1,
        SHOW  = 3'd2,
        ARM   = 3'd3,
        ENTRY = 3'd4,
        WIN   = 3'd5,
        LOSE  = 3'd6
    } state_e;

    localparam int         DIGIT_W_DEF   = 4;
    localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;
    // Feedback taps for x^8+x^6+x^5+x^4+1 with the MSB as the x^8 stage.
    localparam logic [7:0] LFSR_TAPS     = 8'hB8;

    // Timeout shrinks by one per level above 1 and never drops below min_time.
    function automatic logic [3:0] level_to_reconfig(
        input logic [3:0] lvl,
        input logic [3:0] base_time,
        input logic [3:0] min_time
    );
        logic [3:0] dec;
        logic [3:0] t;
        dec = (lvl == 4'd0) ? 4'd0 : (lvl - 4'd1);
        t   = (dec >= base_time) ? min_time : (base_time - dec);
        return (t < min_time) ? min_time : t;
    endfunction

endpackage

// File: rtl/pattern_lfsr.sv
// 8-bit Fibonacci LFSR producing pattern digits; the digit is the low bits
// of the current value, so the caller captures it before requesting a shift.
module pattern_lfsr
    import memory_game_pkg::*;
#(
    parameter int         DIGIT_W = DIGIT_W_DEF,
    parameter logic [7:0] SEED    = LFSR_SEED_DEF
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               load_en,
    input  logic               advance_en,
    output logic [DIGIT_W-1:0] digit
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Next value: reload takes priority over a shift
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_en) begin
            lfsr_d = SEED;
        end else if (advance_en) begin
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR register
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign digit = lfsr_q[DIGIT_W-1:0];

endmodule

// File: rtl/memory_round_ctrl.sv
// Round sequencer for the memory-tester game: builds a pattern, shows it,
// arms the reconfigurable timer and judges the player's key entries.
module memory_round_ctrl
    import memory_game_pkg::*;
#(
    parameter int         DIGIT_W    = DIGIT_W_DEF,
    parameter int         MAX_LEN    = 8,
    parameter int         SHOW_TICKS = 16,
    parameter int         BASE_TIME  = 10,
    parameter int         MIN_TIME   = 2,
    parameter logic [7:0] LFSR_SEED  = LFSR_SEED_DEF
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               start,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_code,
    input  logic               time_out,
    output logic               timer_enable,
    output logic               timer_stop,
    output logic [3:0]         timer_reconfig,
    output logic [DIGIT_W-1:0] disp_digit,
    output logic               disp_valid,
    output logic [3:0]         level,
    output logic [7:0]         score,
    output logic               round_win,
    output logic               game_over,
    output logic               busy
);

    localparam int                IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int                TICK_W    = $clog2(SHOW_TICKS + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SHOW_TICKS - 1);
    localparam logic [3:0]        BASE_T    = 4'(BASE_TIME);
    localparam logic [3:0]        MIN_T     = 4'(MIN_TIME);
    localparam logic [3:0]        LEVEL_MAX = 4'(MAX_LEN - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [DIGIT_W-1:0]  pattern_q [MAX_LEN];
    logic [DIGIT_W-1:0]  pattern_d [MAX_LEN];
    logic                timer_enable_q, timer_enable_d;
    logic                timer_stop_q, timer_stop_d;
    logic [3:0]          timer_reconfig_q, timer_reconfig_d;
    logic [DIGIT_W-1:0]  disp_digit_q, disp_digit_d;
    logic                disp_valid_q, disp_valid_d;
    logic [3:0]          level_q, level_d;
    logic [7:0]          score_q, score_d;
    logic                round_win_q, round_win_d;
    logic                game_over_q, game_over_d;
    logic                busy_q, busy_d;

    logic                advance_s;
    logic [DIGIT_W-1:0]  lfsr_digit_s;
    logic [IDX_W-1:0]    last_idx_s;
    logic [IDX_W-1:0]    idx_inc_s;
    logic [8:0]          score_sum_s;

    pattern_lfsr #(
        .DIGIT_W (DIGIT_W),
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .clock      (clock),
        .rst        (rst),
        .load_en    (1'b0),
        .advance_en (advance_s),
        .digit      (lfsr_digit_s)
    );

    // Pattern length is level+1, so the final digit index equals the level.
    assign last_idx_s  = level_q[IDX_W-1:0];
    assign idx_inc_s   = idx_q + IDX_W'(1);
    assign score_sum_s = {1'b0, score_q} + {5'd0, level_q} + 9'd1;

    // Round sequencing and next values for every registered output
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        tick_d           = tick_q;
        pattern_d        = pattern_q;
        timer_enable_d   = 1'b0;
        timer_stop_d     = 1'b0;
        timer_reconfig_d = timer_reconfig_q;
        disp_digit_d     = disp_digit_q;
        disp_valid_d     = disp_valid_q;
        level_d          = level_q;
        score_d          = score_q;
        round_win_d      = 1'b0;
        advance_s        = 1'b0;

        case (state_q)
            IDLE, LOSE: begin
                if (start) begin
                    level_d = 4'd1;
                    score_d = 8'd0;
                    idx_d   = '0;
                    state_d = GEN;
                end else begin
                    state_d = state_q;
                end
            end
            GEN: begin
                advance_s         = 1'b1;
                pattern_d[idx_q]  = lfsr_digit_s;
                if (idx_q == last_idx_s) begin
                    idx_d        = '0;
                    tick_d       = '0;
                    disp_valid_d = 1'b1;
                    disp_digit_d = pattern_q[0];
                    state_d      = SHOW;
                end else begin
                    idx_d = idx_inc_s;
                end
            end
            SHOW: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (idx_q == last_idx_s) begin
                        idx_d            = '0;
                        disp_valid_d     = 1'b0;
                        disp_digit_d     = '0;
                        timer_enable_d   = 1'b1;
                        timer_reconfig_d = level_to_reconfig(level_q, BASE_T, MIN_T);
                        state_d          = ARM;
                    end else begin
                        idx_d        = idx_inc_s;
                        disp_digit_d = pattern_q[idx_inc_s];
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            ARM: begin
                idx_d   = '0;
                state_d = ENTRY;
            end
            ENTRY: begin
                // Expiry beats a simultaneous key press and needs no stop pulse.
                if (time_out) begin
                    state_d = LOSE;
                end else if (key_valid) begin
                    if (key_code == pattern_q[idx_q]) begin
                        if (idx_q == last_idx_s) begin
                            idx_d        = '0;
                            timer_stop_d = 1'b1;
                            round_win_d  = 1'b1;
                            state_d      = WIN;
                        end else begin
                            idx_d = idx_inc_s;
                        end
                    end else begin
                        timer_stop_d = 1'b1;
                        state_d      = LOSE;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            WIN: begin
                score_d = score_sum_s[8] ? 8'hFF : score_sum_s[7:0];
                level_d = (level_q >= LEVEL_MAX) ? level_q : (level_q + 4'd1);
                idx_d   = '0;
                state_d = GEN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d      = (state_d != IDLE) && (state_d != LOSE);
        game_over_d = (state_d == LOSE);
    end

    // State, pattern store and registered outputs
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            idx_q            <= '0;
            tick_q           <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                pattern_q[i] <= '0;
            end
            timer_enable_q   <= 1'b0;
            timer_stop_q     <= 1'b0;
            timer_reconfig_q <= BASE_T;
            disp_digit_q     <= '0;
            disp_valid_q     <= 1'b0;
            level_q          <= 4'd0;
            score_q          <= 8'd0;
            round_win_q      <= 1'b0;
            game_over_q      <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            tick_q           <= tick_d;
            pattern_q        <= pattern_d;
            timer_enable_q   <= timer_enable_d;
            timer_stop_q     <= timer_stop_d;
            timer_reconfig_q <= timer_reconfig_d;
            disp_digit_q     <= disp_digit_d;
            disp_valid_q     <= disp_valid_d;
            level_q          <= level_d;
            score_q          <= score_d;
            round_win_q      <= round_win_d;
            game_over_q      <= game_over_d;
            busy_q           <= busy_d;
        end
    end

    assign timer_enable   = timer_enable_q;
    assign timer_stop     = timer_stop_q;
    assign timer_reconfig = timer_reconfig_q;
    assign disp_digit     = disp_digit_q;
    assign disp_valid     = disp_valid_q;
    assign level          = level_q;
    assign score          = score_q;
    assign round_win      = round_win_q;
    assign game_over      = game_over_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_memory_round_ctrl.sv
// Directed bench for memory_round_ctrl: plays winning, losing and timeout
// rounds against hand-computed digits, latencies, scores and timeouts.
module tb_memory_round_ctrl;
    import memory_game_pkg::*;

    logic       clock = 1'b0;
    logic       rst;
    logic       start;
    logic       key_valid;
    logic [3:0] key_code;
    logic       time_out;
    logic       timer_enable;
    logic       timer_stop;
    logic [3:0] timer_reconfig;
    logic [3:0] disp_digit;
    logic       disp_valid;
    logic [3:0] level;
    logic [7:0] score;
    logic       round_win;
    logic       game_over;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] lfsr_m;
    logic [3:0] pat [8];
    logic [3:0] first_d;
    logic [3:0] second_d;
    int         errs;
    int         esc;
    int         lvl;
    int         len;
    int         cfg;

    always #5 clock = ~clock;

    memory_round_ctrl dut (
        .clock          (clock),
        .rst            (rst),
        .start          (start),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .time_out       (time_out),
        .timer_enable   (timer_enable),
        .timer_stop     (timer_stop),
        .timer_reconfig (timer_reconfig),
        .disp_digit     (disp_digit),
        .disp_valid     (disp_valid),
        .level          (level),
        .score          (score),
        .round_win      (round_win),
        .game_over      (game_over),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called right after the edge that enters GEN; returns one cycle after ARM.
    task automatic wait_arm(input int n, input logic [3:0] exp_cfg,
                            output logic [3:0] first_seen, output logic [3:0] second_seen);
        int c;
        int derr;
        int berr;
        int k;
        for (int i = 0; i < n; i++) begin
            pat[i] = lfsr_m[3:0];
            lfsr_m = lfsr_step(lfsr_m);
        end
        c = 1; derr = 0; berr = 0; first_seen = 4'h0; second_seen = 4'h0;
        while (timer_enable !== 1'b1 && c < 2000) begin
            if (busy !== 1'b1) berr++;
            if (c > n) begin
                k = (c - n - 1) / 16;
                if (k >= n || disp_valid !== 1'b1 || disp_digit !== pat[k]) derr++;
                if (c == n + 1) first_seen = disp_digit;
                if (c == n + 17) second_seen = disp_digit;
            end else if (disp_valid !== 1'b0) begin
                derr++;
            end
            tick();
            c++;
        end
        chk("arm_latency", c, 1 + n + 16 * n);
        chk("arm_reconfig", timer_reconfig, exp_cfg);
        chk("arm_disp_off", disp_valid, 0);
        chk("show_digits", derr, 0);
        chk("busy_in_round", berr, 0);
        tick();
        chk("enable_width", timer_enable, 0);
    endtask

    task automatic play_keys(input int n);
        int e;
        e = 0;
        for (int i = 0; i < n; i++) begin
            key_valid = 1'b1;
            key_code  = pat[i];
            tick();
            key_valid = 1'b0;
            if (i < n - 1 && (timer_stop !== 1'b0 || round_win !== 1'b0)) e++;
        end
        chk("no_early_stop", e, 0);
        chk("win_stop_pulse", timer_stop, 1);
        chk("round_win_pulse", round_win, 1);
        tick();
        chk("round_win_width", round_win, 0);
        chk("win_stop_width", timer_stop, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; key_valid = 1'b0; key_code = 4'h0; time_out = 1'b0;
        lfsr_m = 8'hA5;
        repeat (3) tick();
        rst = 1'b0;

        errs = 0;
        for (int i = 0; i < 100; i++) begin
            if ({timer_enable, timer_stop, disp_valid, round_win, game_over, busy} !== 6'd0 ||
                disp_digit !== 4'h0 || level !== 4'd0 || score !== 8'd0 ||
                timer_reconfig !== 4'd10) errs++;
            tick();
        end
        chk("idle_quiet", errs, 0);
        chk("reset_reconfig", timer_reconfig, 10);
        chk("reset_level", level, 0);
        chk("reset_busy", busy, 0);

        // Game 1: win level 1 (digits 5,A), then miss the first digit at level 2 (5,A,4)
        pulse_start();
        chk("start_level", level, 1);
        chk("start_busy", busy, 1);
        wait_arm(2, 4'd10, first_d, second_d);
        chk("l1_digit0", first_d, 4'h5);
        chk("l1_digit1", second_d, 4'hA);
        play_keys(2);
        chk("l1_score", score, 2);
        chk("l1_level", level, 2);
        wait_arm(3, 4'd9, first_d, second_d);
        chk("l2_digit0", first_d, 4'h5);
        chk("l2_digit1", second_d, 4'hA);
        key_valid = 1'b1; key_code = pat[0] ^ 4'h1;
        tick();
        key_valid = 1'b0;
        chk("miss_stop", timer_stop, 1);
        chk("miss_game_over", game_over, 1);
        chk("miss_busy", busy, 0);
        chk("miss_no_win", round_win, 0);
        tick();
        chk("miss_stop_width", timer_stop, 0);
        key_valid = 1'b1; key_code = pat[0];
        repeat (3) tick();
        key_valid = 1'b0; time_out = 1'b1;
        tick();
        time_out = 1'b0;
        tick();
        chk("lose_hold_over", game_over, 1);
        chk("lose_hold_level", level, 2);
        chk("lose_hold_score", score, 2);
        chk("lose_hold_stop", timer_stop, 0);

        // Game 2: timer expiry with no keys
        pulse_start();
        chk("restart_level", level, 1);
        chk("restart_score", score, 0);
        chk("restart_over", game_over, 0);
        wait_arm(2, 4'd10, first_d, second_d);
        repeat (5) tick();
        time_out = 1'b1;
        tick();
        time_out = 1'b0;
        chk("timeout_over", game_over, 1);
        chk("timeout_no_stop", timer_stop, 0);

        // Game 3: expiry and a correct key in the same cycle
        pulse_start();
        wait_arm(2, 4'd10, first_d, second_d);
        key_valid = 1'b1; key_code = pat[0]; time_out = 1'b1;
        tick();
        key_valid = 1'b0; time_out = 1'b0;
        chk("tie_over", game_over, 1);
        chk("tie_no_stop", timer_stop, 0);
        chk("tie_busy", busy, 0);

        // Game 4: climb to the level cap and win once more there
        pulse_start();
        esc = 0;
        for (int r = 0; r < 8; r++) begin
            lvl = (r < 7) ? r + 1 : 7;
            len = lvl + 1;
            cfg = (10 - (lvl - 1) < 2) ? 2 : 10 - (lvl - 1);
            wait_arm(len, cfg[3:0], first_d, second_d);
            if (r == 3) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                chk("start_ignored", busy, 1);
            end
            play_keys(len);
            esc = (esc + len > 255) ? 255 : esc + len;
            chk("climb_score", score, esc);
            chk("climb_level", level, (lvl + 1 > 7) ? 7 : lvl + 1);
        end
        chk("final_level", level, 7);
        chk("final_score", score, 43);

        // Reset in the middle of SHOW
        repeat (12) tick();
        chk("pre_reset_show", disp_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        chk("rst_score", score, 0);
        chk("rst_reconfig", timer_reconfig, 10);
        chk("rst_disp_digit", disp_digit, 0);
        chk("rst_stop", timer_stop, 0);
        tick();
        rst = 1'b0;
        lfsr_m = 8'hA5;
        pulse_start();
        wait_arm(2, 4'd10, first_d, second_d);
        chk("reseed_digit0", first_d, 4'h5);

        // Timeout floor at levels beyond the cap
        chk("cfg_floor_l9", level_to_reconfig(4'd9, 4'd10, 4'd2), 2);
        chk("cfg_floor_l12", level_to_reconfig(4'd12, 4'd10, 4'd2), 2);
        chk("cfg_l8", level_to_reconfig(4'd8, 4'd10, 4'd2), 3);
        chk("cfg_l1", level_to_reconfig(4'd1, 4'd10, 4'd2), 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
